gbt_link_sequencer: RTL and testbench

Bring-up and recovery controller for the GBT transceiver bank on the 40 MHz MGMT frame clock. It drives the bank general, TX and RX resets and the SFP tx-disable. It waits for TX/RX ready with timeouts, debounces SFP loss-of-signal and retries failed bring-ups up to a limit. It presents a qualified link_up flag to the system logic, which gates use of the GBT data stream.

---
 rtl/gbt_link_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_gbt_link_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gbt_link_sequencer.sv
// Bring-up and recovery sequencer for the GBT transceiver bank: drives bank resets and
// SFP tx-disable, waits for TX/RX ready with timeouts, filters LOS and retries failed bring-ups.
module gbt_link_sequencer #(
    parameter int unsigned RESET_CYCLES      = 256,
    parameter int unsigned TIMEOUT_CYCLES    = 4_000_000,
    parameter int unsigned LOS_FILTER_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES       = 7
) (
    input  logic       clk_ik,
    input  logic       rstn_ir,
    input  logic       enable_i,
    input  logic       los_i,
    input  logic       tx_ready_i,
    input  logic       rx_ready_i,
    input  logic       clear_fault_i,
    output logic       general_reset_o,
    output logic       reset_tx_o,
    output logic       reset_rx_o,
    output logic       clr_lost_flag_o,
    output logic       sfp_txdisable_o,
    output logic       link_up_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
    localparam int TIMER_W = $clog2(TIMER_MAX + 1);
    localparam int LOS_W   = $clog2(LOS_FILTER_CYCLES + 1);

    localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOS_W-1:0]   LOS_LAST     = LOS_W'(LOS_FILTER_CYCLES - 1);
    localparam logic [3:0]         RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_WAIT_TX = 3'd2,
        S_WAIT_RX = 3'd3,
        S_LINK_UP = 3'd4,
        S_RECOVER = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    // Bit 0 = los, bit 1 = tx_ready, bit 2 = rx_ready
    logic [2:0] sync_meta_reg;
    logic [2:0] sync_reg;
    logic       los_sync;
    logic       tx_ready_sync;
    logic       rx_ready_sync;

    logic             los_filt_reg;
    logic [LOS_W-1:0] los_cnt_reg;

    state_t           state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg;
    logic [3:0]       retry_reg, retry_next;
    logic             fail;
    logic             timed_out;
    logic             reset_done;

    logic general_reset_reg, general_reset_next;
    logic reset_tx_reg, reset_tx_next;
    logic reset_rx_reg, reset_rx_next;
    logic clr_lost_reg, clr_lost_next;
    logic txdisable_reg, txdisable_next;
    logic link_up_reg, link_up_next;
    logic fault_reg, fault_next;

    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            sync_meta_reg <= '0;
            sync_reg      <= '0;
        end else begin
            sync_meta_reg <= {rx_ready_i, tx_ready_i, los_i};
            sync_reg      <= sync_meta_reg;
        end
    end

    assign los_sync      = sync_reg[0];
    assign tx_ready_sync = sync_reg[1];
    assign rx_ready_sync = sync_reg[2];

    // LOS is only accepted after LOS_FILTER_CYCLES consecutive cycles disagreeing with the filtered value
    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            los_filt_reg <= 1'b1;
            los_cnt_reg  <= '0;
        end else if (los_sync != los_filt_reg) begin
            if (los_cnt_reg >= LOS_LAST) begin
                los_filt_reg <= ~los_filt_reg;
                los_cnt_reg  <= '0;
            end else begin
                los_cnt_reg <= los_cnt_reg + 1'b1;
            end
        end else begin
            los_cnt_reg <= '0;
        end
    end

    assign timed_out  = (timer_reg >= TIMEOUT_LAST);
    assign reset_done = (timer_reg >= RESET_LAST);

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        fail       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (enable_i && !los_filt_reg) state_next = S_RESET;
            end
            S_RESET: begin
                if (reset_done) state_next = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_ready_sync)  state_next = S_WAIT_RX;
                else if (timed_out) fail = 1'b1;
            end
            S_WAIT_RX: begin
                if (rx_ready_sync)  state_next = S_LINK_UP;
                else if (timed_out) fail = 1'b1;
            end
            S_LINK_UP: begin
                if (!rx_ready_sync)      state_next = S_RECOVER;
                else if (!tx_ready_sync) fail = 1'b1;
            end
            S_RECOVER: begin
                if (reset_done) state_next = S_WAIT_RX;
            end
            S_FAULT: begin
                if (clear_fault_i) begin
                    state_next = S_IDLE;
                    retry_next = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (fail) begin
            if (retry_reg == RETRY_LIMIT) begin
                state_next = S_FAULT;
            end else begin
                retry_next = retry_reg + 1'b1;
                state_next = S_RESET;
            end
        end

        // Disable and loss-of-signal abort any attempt without counting it as a failure
        if (state_reg != S_FAULT && (!enable_i || los_filt_reg)) begin
            state_next = S_IDLE;
            retry_next = retry_reg;
        end

        if (state_next == S_LINK_UP) retry_next = '0;
    end

    always_comb begin
        general_reset_next = (state_next == S_IDLE) || (state_next == S_RESET) || (state_next == S_FAULT);
        reset_tx_next      = (state_next == S_RESET);
        reset_rx_next      = (state_next == S_RESET) || (state_next == S_RECOVER);
        txdisable_next     = (state_next == S_IDLE) || (state_next == S_FAULT);
        link_up_next       = (state_next == S_LINK_UP);
        fault_next         = (state_next == S_FAULT);
        clr_lost_next      = (state_reg == S_WAIT_RX) && (state_next == S_LINK_UP);
    end

    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            state_reg         <= S_IDLE;
            retry_reg         <= '0;
            general_reset_reg <= 1'b1;
            reset_tx_reg      <= 1'b0;
            reset_rx_reg      <= 1'b0;
            txdisable_reg     <= 1'b1;
            link_up_reg       <= 1'b0;
            fault_reg         <= 1'b0;
            clr_lost_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            retry_reg         <= retry_next;
            general_reset_reg <= general_reset_next;
            reset_tx_reg      <= reset_tx_next;
            reset_rx_reg      <= reset_rx_next;
            txdisable_reg     <= txdisable_next;
            link_up_reg       <= link_up_next;
            fault_reg         <= fault_next;
            clr_lost_reg      <= clr_lost_next;
        end
    end

    // Shared timer restarts on every state change and sticks at all-ones
    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            timer_reg <= '0;
        end else if (state_next != state_reg) begin
            timer_reg <= '0;
        end else if (timer_reg != '1) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign general_reset_o = general_reset_reg;
    assign reset_tx_o      = reset_tx_reg;
    assign reset_rx_o      = reset_rx_reg;
    assign clr_lost_flag_o = clr_lost_reg;
    assign sfp_txdisable_o = txdisable_reg;
    assign link_up_o       = link_up_reg;
    assign fault_o         = fault_reg;
    assign retry_cnt_o     = retry_reg;
    assign state_o         = state_reg;

endmodule

// File: tb/tb_gbt_link_sequencer.sv
// Directed bench for gbt_link_sequencer: hand-computed vector table plus explicit
// sequences for bring-up timing, retries/fault, enable drop and mid-run reset.
module tb_gbt_link_sequencer;

    logic       clk_ik = 1'b0;
    logic       rstn_ir = 1'b0;
    logic       enable_i = 1'b0;
    logic       los_i = 1'b0;
    logic       tx_ready_i = 1'b0;
    logic       rx_ready_i = 1'b0;
    logic       clear_fault_i = 1'b0;
    logic       general_reset_o;
    logic       reset_tx_o;
    logic       reset_rx_o;
    logic       clr_lost_flag_o;
    logic       sfp_txdisable_o;
    logic       link_up_o;
    logic       fault_o;
    logic [3:0] retry_cnt_o;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    gbt_link_sequencer #(
        .RESET_CYCLES     (256),
        .TIMEOUT_CYCLES   (1000),
        .LOS_FILTER_CYCLES(1024),
        .MAX_RETRIES      (7)
    ) dut (
        .clk_ik         (clk_ik),
        .rstn_ir        (rstn_ir),
        .enable_i       (enable_i),
        .los_i          (los_i),
        .tx_ready_i     (tx_ready_i),
        .rx_ready_i     (rx_ready_i),
        .clear_fault_i  (clear_fault_i),
        .general_reset_o(general_reset_o),
        .reset_tx_o     (reset_tx_o),
        .reset_rx_o     (reset_rx_o),
        .clr_lost_flag_o(clr_lost_flag_o),
        .sfp_txdisable_o(sfp_txdisable_o),
        .link_up_o      (link_up_o),
        .fault_o        (fault_o),
        .retry_cnt_o    (retry_cnt_o),
        .state_o        (state_o)
    );

    always #5 clk_ik = ~clk_ik;

    // outs = {general_reset, reset_tx, reset_rx, txdisable, link_up, fault, clr_lost}
    typedef struct {
        string      name;
        logic       en;
        logic       los;
        logic       tx;
        logic       rx;
        int         cycles;
        logic [2:0] st;
        logic [6:0] outs;
        logic [3:0] retry;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] dut_outs();
        return {general_reset_o, reset_tx_o, reset_rx_o, sfp_txdisable_o, link_up_o, fault_o, clr_lost_flag_o};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_ik);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] st, input logic [6:0] outs, input logic [3:0] retry);
        check({name, " state"}, 32'(state_o), 32'(st));
        check({name, " outs"}, 32'(dut_outs()), 32'(outs));
        check({name, " retry"}, 32'(retry_cnt_o), 32'(retry));
    endtask

    initial begin
        int cnt;

        // Vectors start in LINK_UP with en=1, tx=1, rx=1, los=0
        vecs.push_back('{"los_glitch_hold", 1'b1, 1'b1, 1'b1, 1'b1, 1000, 3'd4, 7'b0000100, 4'd0});
        vecs.push_back('{"los_glitch_end",  1'b1, 1'b0, 1'b1, 1'b1,   20, 3'd4, 7'b0000100, 4'd0});
        vecs.push_back('{"rx_drop",         1'b1, 1'b0, 1'b1, 1'b0,   10, 3'd5, 7'b0010000, 4'd0});
        vecs.push_back('{"recover_mid",     1'b1, 1'b0, 1'b1, 1'b1,  240, 3'd5, 7'b0010000, 4'd0});
        vecs.push_back('{"recover_last",    1'b1, 1'b0, 1'b1, 1'b1,    8, 3'd5, 7'b0010000, 4'd0});
        vecs.push_back('{"recover_exit",    1'b1, 1'b0, 1'b1, 1'b1,    1, 3'd3, 7'b0000000, 4'd0});
        vecs.push_back('{"relink",          1'b1, 1'b0, 1'b1, 1'b1,    1, 3'd4, 7'b0000101, 4'd0});
        vecs.push_back('{"relink_hold",     1'b1, 1'b0, 1'b1, 1'b1,    1, 3'd4, 7'b0000100, 4'd0});
        vecs.push_back('{"los_long_pre",    1'b1, 1'b1, 1'b1, 1'b1, 1026, 3'd4, 7'b0000100, 4'd0});
        vecs.push_back('{"los_long_idle",   1'b1, 1'b1, 1'b1, 1'b1,    1, 3'd0, 7'b1001000, 4'd0});
        vecs.push_back('{"los_clear_pre",   1'b1, 1'b0, 1'b0, 1'b0, 1026, 3'd0, 7'b1001000, 4'd0});
        vecs.push_back('{"los_clear_reset", 1'b1, 1'b0, 1'b0, 1'b0,    1, 3'd1, 7'b1110000, 4'd0});

        // Reset values
        tick(3);
        check_all("reset", 3'd0, 7'b1001000, 4'd0);

        // Nominal bring-up: filtered LOS starts at 1 and needs 1024 cycles to clear
        enable_i = 1'b1;
        rstn_ir  = 1'b1;
        tick(1024);
        check("idle_before_filter", 32'(state_o), 32'd0);
        tick(1);
        check_all("reset_entry", 3'd1, 7'b1110000, 4'd0);
        cnt = 0;
        while (general_reset_o && cnt < 2000) begin
            cnt++;
            tick(1);
        end
        check("general_reset_len", 32'(cnt), 32'd256);
        check_all("wait_tx", 3'd2, 7'b0000000, 4'd0);
        $display("bring-up: RESET held %0d cycles", cnt);

        tick(50);
        tx_ready_i = 1'b1;
        tick(2);
        check("tx_sync_latency", 32'(state_o), 32'd2);
        tick(1);
        check("wait_rx", 32'(state_o), 32'd3);
        tick(100);
        rx_ready_i = 1'b1;
        tick(2);
        check_all("rx_sync_latency", 3'd3, 7'b0000000, 4'd0);
        tick(1);
        check_all("link_up", 3'd4, 7'b0000101, 4'd0);
        tick(1);
        check_all("link_up_hold", 3'd4, 7'b0000100, 4'd0);
        $display("bring-up: link_up=%0b", link_up_o);

        // Table-driven vectors
        foreach (vecs[i]) begin
            enable_i   = vecs[i].en;
            los_i      = vecs[i].los;
            tx_ready_i = vecs[i].tx;
            rx_ready_i = vecs[i].rx;
            tick(vecs[i].cycles);
            check_all(vecs[i].name, vecs[i].st, vecs[i].outs, vecs[i].retry);
            $display("vec %s: state=%0d outs=%07b retry=%0d", vecs[i].name, state_o, dut_outs(), retry_cnt_o);
        end

        // Timeouts with tx_ready held low: 256 RESET + 1000 WAIT_TX per attempt
        for (int k = 1; k <= 8; k++) begin
            tick(1255);
            check_all($sformatf("wait_tx_%0d", k), 3'd2, 7'b0000000, 4'(k - 1));
            tick(1);
            if (k < 8) check_all($sformatf("retry_%0d", k), 3'd1, 7'b1110000, 4'(k));
            else       check_all("fault", 3'd6, 7'b1001010, 4'd7);
            $display("timeout %0d: state=%0d retry=%0d", k, state_o, retry_cnt_o);
        end

        // FAULT holds through enable=0 and only leaves on clear_fault_i
        enable_i = 1'b0;
        tick(5);
        check_all("fault_disabled", 3'd6, 7'b1001010, 4'd7);
        enable_i = 1'b1;
        tick(1);
        check("fault_no_clear", 32'(state_o), 32'd6);
        clear_fault_i = 1'b1;
        tick(1);
        clear_fault_i = 1'b0;
        check_all("fault_cleared", 3'd0, 7'b1001000, 4'd0);
        tick(1);
        check("rebringup", 32'(state_o), 32'd1);
        $display("fault clear: state=%0d", state_o);

        // enable drop in WAIT_RX
        tx_ready_i = 1'b1;
        tick(257);
        check("wait_rx_again", 32'(state_o), 32'd3);
        enable_i = 1'b0;
        tick(1);
        check_all("enable_drop", 3'd0, 7'b1001000, 4'd0);
        enable_i = 1'b1;
        tick(1);
        check("reenable", 32'(state_o), 32'd1);
        tick(300);
        check("wait_rx_pre_rst", 32'(state_o), 32'd3);

        // Asynchronous reset between clock edges
        #2;
        rstn_ir = 1'b0;
        #1;
        check_all("async_reset", 3'd0, 7'b1001000, 4'd0);
        $display("async reset: state=%0d", state_o);
        @(negedge clk_ik);
        rstn_ir = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
